// File: rtl/demux_pkg.sv
// ============================================================================
// Module : demux_pkg
// Brief  : Shared constants and lane-state encoding for demux1_4_reg.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

  localparam int DATA_W    = 16;
  localparam int NUM_LANES = 4;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_e;

endpackage : demux_pkg

`default_nettype wire

// File: rtl/demux_lane.sv
// ============================================================================
// Module : demux_lane
// Brief  : One output lane: data register plus EMPTY/FULL valid tracking.
//          With DEMUX_OVF_EN defined, also flags writes that hit a full lane.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module demux_lane
  import demux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic             i_ack,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_valid
`ifdef DEMUX_OVF_EN
  ,
  output logic             o_ovf_pulse
`endif
);

  lane_state_e      r_state;
  lane_state_e      w_state_next;
  logic [WIDTH-1:0] r_data;

  // A write to this lane always wins over a same-edge acknowledge.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY:   if (i_we) w_state_next = FULL;
      FULL:    if (!i_we && i_ack) w_state_next = EMPTY;
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_we) r_data <= i_d;
    end
  end

  assign o_q     = r_data;
  assign o_valid = (r_state == FULL);

`ifdef DEMUX_OVF_EN
  assign o_ovf_pulse = i_we && (r_state == FULL) && !i_ack;
`endif

endmodule : demux_lane

`default_nettype wire

// File: rtl/demux1_4_reg.sv
// ============================================================================
// Module : demux1_4_reg
// Brief  : Registered 1:4 demultiplexer with per-lane valid/ack handshake.
//          Optional sticky overwrite flag enabled by macro DEMUX_OVF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module demux1_4_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             S0,
  input  logic             S1,
  input  logic             WE,
  input  logic             ACK0,
  input  logic             ACK1,
  input  logic             ACK2,
  input  logic             ACK3,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic             V0,
  output logic             V1,
  output logic             V2,
  output logic             V3,
  output logic             OVF
);

  logic [1:0]           w_sel;
  logic [NUM_LANES-1:0] w_lane_we;
  logic [NUM_LANES-1:0] w_ack;
  logic [NUM_LANES-1:0] w_valid;
  logic [WIDTH-1:0]     w_q [NUM_LANES];

  assign w_sel = {S1, S0};
  assign w_ack = {ACK3, ACK2, ACK1, ACK0};

  always_comb begin
    w_lane_we = '0;
    if (WE) begin
      case (w_sel)
        LANE0:   w_lane_we[0] = 1'b1;
        LANE1:   w_lane_we[1] = 1'b1;
        LANE2:   w_lane_we[2] = 1'b1;
        LANE3:   w_lane_we[3] = 1'b1;
        default: w_lane_we = '0;
      endcase
    end
  end

`ifdef DEMUX_OVF_EN
  logic [NUM_LANES-1:0] w_ovf_pulse;
  logic                 r_ovf;
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk        (CLK),
      .rst        (RST),
      .i_we       (w_lane_we[i]),
      .i_ack      (w_ack[i]),
      .i_d        (D),
      .o_q        (w_q[i]),
      .o_valid    (w_valid[i])
`ifdef DEMUX_OVF_EN
      ,
      .o_ovf_pulse(w_ovf_pulse[i])
`endif
    );
  end

  assign O0 = w_q[0];
  assign O1 = w_q[1];
  assign O2 = w_q[2];
  assign O3 = w_q[3];
  assign V0 = w_valid[0];
  assign V1 = w_valid[1];
  assign V2 = w_valid[2];
  assign V3 = w_valid[3];

`ifdef DEMUX_OVF_EN
  // Sticky until reset; the overwriting write itself still goes through.
  always_ff @(posedge CLK) begin
    if (RST)               r_ovf <= 1'b0;
    else if (|w_ovf_pulse) r_ovf <= 1'b1;
  end
  assign OVF = r_ovf;
`else
  assign OVF = 1'b0;
`endif

endmodule : demux1_4_reg

`default_nettype wire

// File: tb/tb_demux1_4_reg.sv
// ============================================================================
// Module : tb_demux1_4_reg
// Brief  : Table-driven self-checking bench for demux1_4_reg.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_demux1_4_reg;

`ifdef DEMUX_OVF_EN
  localparam bit c_ovf_en = 1'b1;
`else
  localparam bit c_ovf_en = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] d;
  logic        s0, s1, we;
  logic [3:0]  ack;
  logic [15:0] o0, o1, o2, o3;
  logic        v0, v1, v2, v3;
  logic        ovf;

  int n_vec;
  int n_bad;

  demux1_4_reg #(.WIDTH(16)) dut (
    .CLK (clk),  .RST (rst),  .D   (d),
    .S0  (s0),   .S1  (s1),   .WE  (we),
    .ACK0(ack[0]), .ACK1(ack[1]), .ACK2(ack[2]), .ACK3(ack[3]),
    .O0  (o0),   .O1  (o1),   .O2  (o2),   .O3  (o3),
    .V0  (v0),   .V1  (v1),   .V2  (v2),   .V3  (v3),
    .OVF (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] d;
    logic [3:0]  ack;
    logic [15:0] eo0, eo1, eo2, eo3;
    logic [3:0]  ev;
    logic        eovf;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic w, logic [1:0] s, logic [15:0] dd,
                              logic [3:0] a, logic [15:0] e0, logic [15:0] e1,
                              logic [15:0] e2, logic [15:0] e3, logic [3:0] v,
                              logic ov);
    vec_t t;
    t.rst = r; t.we = w; t.sel = s; t.d = dd; t.ack = a;
    t.eo0 = e0; t.eo1 = e1; t.eo2 = e2; t.eo3 = e3; t.ev = v; t.eovf = ov;
    return t;
  endfunction

  task automatic check(string name, logic [15:0] e0, logic [15:0] e1,
                       logic [15:0] e2, logic [15:0] e3, logic [3:0] ev,
                       logic eovf);
    logic [3:0] av;
    av = {v3, v2, v1, v0};
    n_vec++;
    if (o0 !== e0 || o1 !== e1 || o2 !== e2 || o3 !== e3 || av !== ev || ovf !== eovf) begin
      n_bad++;
      $display("FAIL %s: got O=%h/%h/%h/%h V=%b OVF=%b, want O=%h/%h/%h/%h V=%b OVF=%b",
               name, o0, o1, o2, o3, av, ovf, e0, e1, e2, e3, ev, eovf);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b0; we = 1'b0; d = '0; s0 = 1'b0; s1 = 1'b0; ack = '0;

    //            rst we  sel    d        ack      O0     O1     O2      O3      V        OVF
    vt.push_back(mk(1, 1, 2'd0, 16'hFFFF, 4'b0000, 16'd0, 16'd0, 16'd0,  16'd0,  4'b0000, 1'b0));
    vt.push_back(mk(0, 1, 2'd0, 16'd2,    4'b0000, 16'd2, 16'd0, 16'd0,  16'd0,  4'b0001, 1'b0));
    vt.push_back(mk(0, 1, 2'd1, 16'd5,    4'b0000, 16'd2, 16'd5, 16'd0,  16'd0,  4'b0011, 1'b0));
    vt.push_back(mk(0, 1, 2'd2, 16'd7,    4'b0000, 16'd2, 16'd5, 16'd7,  16'd0,  4'b0111, 1'b0));
    vt.push_back(mk(0, 1, 2'd3, 16'd11,   4'b0000, 16'd2, 16'd5, 16'd7,  16'd11, 4'b1111, 1'b0));
    vt.push_back(mk(0, 0, 2'd1, 16'h5555, 4'b0010, 16'd2, 16'd5, 16'd7,  16'd11, 4'b1101, 1'b0));
    vt.push_back(mk(0, 0, 2'd1, 16'h5555, 4'b0010, 16'd2, 16'd5, 16'd7,  16'd11, 4'b1101, 1'b0));
    // Write and ack on the same full lane: write wins, no overwrite error
    vt.push_back(mk(0, 1, 2'd2, 16'd9,    4'b0100, 16'd2, 16'd5, 16'd9,  16'd11, 4'b1101, 1'b0));
    vt.push_back(mk(0, 1, 2'd3, 16'd13,   4'b0000, 16'd2, 16'd5, 16'd9,  16'd13, 4'b1101, c_ovf_en));
    vt.push_back(mk(0, 1, 2'd1, 16'd20,   4'b0000, 16'd2, 16'd20, 16'd9, 16'd13, 4'b1111, c_ovf_en));
    // Write lane 0 while acking lane 1: both take effect
    vt.push_back(mk(0, 1, 2'd0, 16'd3,    4'b0010, 16'd3, 16'd20, 16'd9, 16'd13, 4'b1101, c_ovf_en));
    vt.push_back(mk(0, 0, 2'd0, 16'd0,    4'b0101, 16'd3, 16'd20, 16'd9, 16'd13, 4'b1000, c_ovf_en));
    vt.push_back(mk(0, 0, 2'd0, 16'd0,    4'b0001, 16'd3, 16'd20, 16'd9, 16'd13, 4'b1000, c_ovf_en));
    vt.push_back(mk(1, 1, 2'd2, 16'hBEEF, 4'b1111, 16'd0, 16'd0,  16'd0, 16'd0,  4'b0000, 1'b0));
    vt.push_back(mk(0, 0, 2'd3, 16'hAAAA, 4'b1111, 16'd0, 16'd0,  16'd0, 16'd0,  4'b0000, 1'b0));
    vt.push_back(mk(0, 0, 2'd1, 16'h1111, 4'b0000, 16'd0, 16'd0,  16'd0, 16'd0,  4'b0000, 1'b0));
    vt.push_back(mk(0, 1, 2'd3, 16'hFFFF, 4'b0000, 16'd0, 16'd0,  16'd0, 16'hFFFF, 4'b1000, 1'b0));
    vt.push_back(mk(0, 1, 2'd3, 16'd1,    4'b0000, 16'd0, 16'd0,  16'd0, 16'd1,  4'b1000, c_ovf_en));
    vt.push_back(mk(0, 0, 2'd2, 16'd0,    4'b0111, 16'd0, 16'd0,  16'd0, 16'd1,  4'b1000, c_ovf_en));
    vt.push_back(mk(1, 0, 2'd0, 16'd0,    4'b0000, 16'd0, 16'd0,  16'd0, 16'd0,  4'b0000, 1'b0));

    @(negedge clk);
    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].rst; we = vt[i].we; {s1, s0} = vt[i].sel; d = vt[i].d; ack = vt[i].ack;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), vt[i].eo0, vt[i].eo1, vt[i].eo2, vt[i].eo3,
            vt[i].ev, vt[i].eovf);
    end

    // Latency: nothing visible before the write edge, data present right after it
    rst = 1'b0; we = 1'b1; {s1, s0} = 2'b10; d = 16'h1234; ack = '0;
    #1;
    check("pre_edge", 16'd0, 16'd0, 16'd0, 16'd0, 4'b0000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("post_edge", 16'd0, 16'd0, 16'h1234, 16'd0, 4'b0100, 1'b0);
    we = 1'b0; {s1, s0} = 2'b01; d = 16'hDEAD;
    @(posedge clk);
    @(negedge clk);
    check("hold", 16'd0, 16'd0, 16'h1234, 16'd0, 4'b0100, 1'b0);
    // Ack clears valid but the lane keeps its last data
    ack = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    check("ack_keeps_data", 16'd0, 16'd0, 16'h1234, 16'd0, 4'b0000, 1'b0);
    ack = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_demux1_4_reg

`default_nettype wire
